// File: rtl/calc_key_entry.sv
// Keypad entry sequencer in front of the Calkko core: builds BCD operands,
// latches the operation and steps the calculator state machine.
module calc_key_entry #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid,
    input  logic [4:0]  key_code,
    input  logic        set,
    input  logic [15:0] number,
    output logic [3:0]  A1,
    output logic [3:0]  A2,
    output logic [3:0]  A3,
    output logic [3:0]  A4,
    output logic [3:0]  B1,
    output logic [3:0]  B2,
    output logic [3:0]  B3,
    output logic [3:0]  B4,
    output logic [1:0]  ST,
    output logic [2:0]  ST_L,
    output logic        key_err
);

    localparam logic [1:0] S_A   = 2'd0;
    localparam logic [1:0] S_B   = 2'd1;
    localparam logic [1:0] S_OBL = 2'd2;
    localparam logic [1:0] S_WYN = 2'd3;

    localparam logic [2:0] SL_ADD = 3'd0;

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    logic [2:0]    cnt_a;
    logic [2:0]    cnt_b;
    logic [TW-1:0] tmo;

    logic       is_dig;
    logic       is_op;
    logic       is_eq;
    logic       is_clr;
    logic       is_bksp;
    logic       is_bad;
    logic [4:0] op_diff;
    logic [2:0] op_code;
    logic [3:0] digit;

    always_comb begin
        is_dig  = key_valid && (key_code <= 5'd9);
        is_op   = key_valid && (key_code >= 5'd10) && (key_code <= 5'd14);
        is_eq   = key_valid && (key_code == 5'd15);
        is_clr  = key_valid && (key_code == 5'd16);
        is_bksp = key_valid && (key_code == 5'd17);
        is_bad  = key_valid && (key_code >= 5'd18);
        op_diff = key_code - 5'd10;
        op_code = op_diff[2:0];
        digit   = key_code[3:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            A1 <= '0; A2 <= '0; A3 <= '0; A4 <= '0;
            B1 <= '0; B2 <= '0; B3 <= '0; B4 <= '0;
            ST      <= S_A;
            ST_L    <= SL_ADD;
            key_err <= 1'b0;
            cnt_a   <= '0;
            cnt_b   <= '0;
            tmo     <= '0;
        end else begin
            key_err <= 1'b0;
            if (is_clr) begin
                A1 <= '0; A2 <= '0; A3 <= '0; A4 <= '0;
                B1 <= '0; B2 <= '0; B3 <= '0; B4 <= '0;
                ST    <= S_A;
                ST_L  <= SL_ADD;
                cnt_a <= '0;
                cnt_b <= '0;
                tmo   <= '0;
            end else begin
                case (ST)
                    S_A: begin
                        if (is_bad || is_eq) begin
                            key_err <= 1'b1;
                        end else if (is_dig) begin
                            if (cnt_a == 3'd4) begin
                                key_err <= 1'b1;
                            end else begin
                                A1 <= A2; A2 <= A3; A3 <= A4; A4 <= digit;
                                cnt_a <= cnt_a + 3'd1;
                            end
                        end else if (is_bksp) begin
                            if (cnt_a == 3'd0) begin
                                key_err <= 1'b1;
                            end else begin
                                A4 <= A3; A3 <= A2; A2 <= A1; A1 <= '0;
                                cnt_a <= cnt_a - 3'd1;
                            end
                        end else if (is_op) begin
                            ST_L <= op_code;
                            ST   <= S_B;
                        end
                    end
                    S_B: begin
                        if (is_bad) begin
                            key_err <= 1'b1;
                        end else if (is_dig) begin
                            if (cnt_b == 3'd4) begin
                                key_err <= 1'b1;
                            end else begin
                                B1 <= B2; B2 <= B3; B3 <= B4; B4 <= digit;
                                cnt_b <= cnt_b + 3'd1;
                            end
                        end else if (is_bksp) begin
                            if (cnt_b == 3'd0) begin
                                key_err <= 1'b1;
                            end else begin
                                B4 <= B3; B3 <= B2; B2 <= B1; B1 <= '0;
                                cnt_b <= cnt_b - 3'd1;
                            end
                        end else if (is_op) begin
                            // operator may only be swapped before B is typed
                            if (cnt_b == 3'd0) begin
                                ST_L <= op_code;
                            end else begin
                                key_err <= 1'b1;
                            end
                        end else if (is_eq) begin
                            ST  <= S_OBL;
                            tmo <= '0;
                        end
                    end
                    S_OBL: begin
                        if (key_valid) begin
                            key_err <= 1'b1;
                        end
                        if (set) begin
                            ST <= S_WYN;
                        end else if (tmo == TMO_LAST) begin
                            ST      <= S_B;
                            key_err <= 1'b1;
                        end else begin
                            tmo <= tmo + 1'b1;
                        end
                    end
                    default: begin
                        if (is_bad || is_eq || is_bksp) begin
                            key_err <= 1'b1;
                        end else if (is_dig) begin
                            A1 <= '0; A2 <= '0; A3 <= '0; A4 <= digit;
                            B1 <= '0; B2 <= '0; B3 <= '0; B4 <= '0;
                            cnt_a <= 3'd1;
                            cnt_b <= 3'd0;
                            ST    <= S_A;
                        end else if (is_op) begin
                            // chain: previous result becomes operand A
                            A1 <= number[15:12];
                            A2 <= number[11:8];
                            A3 <= number[7:4];
                            A4 <= number[3:0];
                            B1 <= '0; B2 <= '0; B3 <= '0; B4 <= '0;
                            cnt_a <= 3'd4;
                            cnt_b <= 3'd0;
                            ST_L  <= op_code;
                            ST    <= S_B;
                        end
                    end
                endcase
            end
        end
    end

endmodule
